pipe_perf_monitor: RTL and testbench
====================================

PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 Parameter: WIDTH, 32, width of all counters, limit and snapshot outputs (legal 8..32).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  one-cycle pulse; clears counters and begins a measurement run.
REQ-005 stall_i  input  1  hazard-unit stall request.
REQ-006 branch_i  input  1  control-unit branch indication; qualifies stall.
REQ-007 flush_i  input  1  IF flush from ID-stage branch resolution.
REQ-008 limit_i  input  WIDTH  run length in cycles; 0 = unlimited; sampled only on the accepted start_i.
REQ-009 snap_req_i  input  1  snapshot request, 4-phase handshake.
REQ-010 snap_ack_o  output  1  snapshot acknowledge.
REQ-011 snap_cycle_o / snap_stall_o / snap_flush_o  output  WIDTH each  captured counter values.
REQ-012 cycle_o / stall_cnt_o / flush_cnt_o  output  WIDTH each  live counter values, registered.
REQ-013 state_o  output  2  FSM state: 0 IDLE, 1 RUN, 2 DONE.
REQ-014 done_o  output  1  high while in DONE.

Function
REQ-015 FSM transitions: IDLE to RUN on start_i; RUN to DONE when the run limit is reached; DONE to RUN on start_i; no other transitions except reset.
REQ-016 start_i accepted in any state: counters cleared to 0, limit_i latched, state RUN on next edge; a start_i in RUN restarts the run.
REQ-017 In RUN, each cycle: cycle_o +1; stall_cnt_o +1 iff stall_i=1 and branch_i=0; flush_cnt_o +1 iff flush_i=1.
REQ-018 Stall and flush counts are independent: both increment in the same cycle when both conditions hold.
REQ-019 Cycle of start_i acceptance: no counting; first counted cycle is the one after.
REQ-020 Limit: with latched limit L≠0, the edge that makes cycle_o equal L also moves state to DONE; exactly L cycles counted.
REQ-021 Latched limit 0: run never ends on its own; cycle_o saturates.
REQ-022 All counters saturate at 2^WIDTH-1 and never wrap; other counters keep counting.
REQ-023 IDLE and DONE: all counters hold; stall_i, branch_i and flush_i are ignored.
REQ-024 Snapshot: when snap_req_i=1 and snap_ack_o=0, snap_*_o capture the pre-edge live counter values and snap_ack_o rises on that same edge.
REQ-025 snap_ack_o stays high while snap_req_i=1; it falls on the first edge with snap_req_i=0; a new capture requires req low then high again.
REQ-026 snap_*_o hold between captures; snapshots work in every state and never disturb live counting.
REQ-027 Simultaneous start_i and snapshot capture: snapshot takes the pre-clear values; counters clear.
REQ-028 done_o equals (state_o==2), registered; no combinational input-to-output paths.

Reset
REQ-029 rst_i=1 at an edge: state IDLE; all counters, snap_*_o, latched limit, snap_ack_o and done_o set to 0.
REQ-030 Reset has priority over start_i and snapshot capture in the same cycle; reset mid-run aborts the run with no DONE.

Verification
REQ-031 Reset; start_i with limit_i=10; stall_i=1 and branch_i=0 on cycles 3–4; flush_i on cycle 6 -> after 10 counted cycles: DONE, cycle_o=10, stall_cnt_o=2, flush_cnt_o=1, done_o=1.
REQ-032 In RUN, stall_i=1 and branch_i=1 for 5 cycles -> stall_cnt_o unchanged; stall_i=1, branch_i=0 and flush_i=1 for 1 cycle -> stall and flush each +1.
REQ-033 WIDTH=8, limit_i=0, 300 cycles in RUN -> cycle_o=255 and state_o stays RUN.
REQ-034 Raise snap_req_i at cycle_o=7 and hold it 4 cycles -> snap_cycle_o=7, ack high for 4 cycles, then low one edge after req drops; live cycle_o keeps advancing.
REQ-035 start_i during RUN at cycle_o=20 with limit_i=3 -> counters cleared, DONE after 3 cycles; rst_i pulse mid-run -> IDLE with all counters 0.
REQ-036 start_i and capture on the same edge with cycle_o=5 -> snap_cycle_o=5 and cycle_o=0.

Source files
------------

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run-bounded pipeline cycle/stall/flush counters with 4-phase snapshot capture
module pipe_perf_monitor #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] limit_i,
   input  logic             snap_req_i,
   output logic             snap_ack_o,
   output logic [WIDTH-1:0] snap_cycle_o,
   output logic [WIDTH-1:0] snap_stall_o,
   output logic [WIDTH-1:0] snap_flush_o,
   output logic [WIDTH-1:0] cycle_o,
   output logic [WIDTH-1:0] stall_cnt_o,
   output logic [WIDTH-1:0] flush_cnt_o,
   output logic [1:0]       state_o,
   output logic             done_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_limit;
   logic [WIDTH-1:0] r_cycle;
   logic [WIDTH-1:0] r_stall;
   logic [WIDTH-1:0] r_flush;
   logic [WIDTH-1:0] r_snap_cycle;
   logic [WIDTH-1:0] r_snap_stall;
   logic [WIDTH-1:0] r_snap_flush;
   logic             r_ack;
   logic             r_done;
   logic [WIDTH-1:0] w_cycle_nxt;
   logic [WIDTH-1:0] w_stall_nxt;
   logic [WIDTH-1:0] w_flush_nxt;
   logic             w_hit_limit;
   logic             w_capture;
   always_comb begin
      w_cycle_nxt = (&r_cycle) ? r_cycle : r_cycle + WIDTH'(1);
      w_stall_nxt = (stall_i && !branch_i && !(&r_stall)) ? r_stall + WIDTH'(1) : r_stall;
      w_flush_nxt = (flush_i && !(&r_flush)) ? r_flush + WIDTH'(1) : r_flush;
      w_hit_limit = (r_limit != '0) && (w_cycle_nxt == r_limit);
      w_capture   = snap_req_i && !r_ack;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_limit      <= '0;
         r_cycle      <= '0;
         r_stall      <= '0;
         r_flush      <= '0;
         r_snap_cycle <= '0;
         r_snap_stall <= '0;
         r_snap_flush <= '0;
         r_ack        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_ack <= snap_req_i;
         if (w_capture) begin
            r_snap_cycle <= r_cycle;
            r_snap_stall <= r_stall;
            r_snap_flush <= r_flush;
         end
         if (start_i) begin
            r_state <= RUN;
            r_limit <= limit_i;
            r_cycle <= '0;
            r_stall <= '0;
            r_flush <= '0;
            r_done  <= 1'b0;
         end else if (r_state == RUN) begin
            r_cycle <= w_cycle_nxt;
            r_stall <= w_stall_nxt;
            r_flush <= w_flush_nxt;
            r_state <= w_hit_limit ? DONE : RUN;
            r_done  <= w_hit_limit;
         end
      end
   end
   assign snap_ack_o   = r_ack;
   assign snap_cycle_o = r_snap_cycle;
   assign snap_stall_o = r_snap_stall;
   assign snap_flush_o = r_snap_flush;
   assign cycle_o      = r_cycle;
   assign stall_cnt_o  = r_stall;
   assign flush_cnt_o  = r_flush;
   assign state_o      = r_state;
   assign done_o       = r_done;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: directed stimulus with a queued scoreboard checked by a separate monitor
module tb_pipe_perf_monitor;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_i, start_i, stall_i, branch_i, flush_i, snap_req_i;
   logic [W-1:0] limit_i;
   logic         snap_ack_o, done_o;
   logic [W-1:0] snap_cycle_o, snap_stall_o, snap_flush_o, cycle_o, stall_cnt_o, flush_cnt_o;
   logic [1:0]   state_o;
   int checks = 0;
   int errors = 0;
   typedef struct {
      string        name;
      logic [1:0]   st;
      logic         dn;
      logic         ack;
      logic [W-1:0] cyc, stl, fls;
   } live_t;
   typedef struct {
      string        name;
      logic [W-1:0] cyc, stl, fls;
   } snap_t;
   live_t live_q[$];
   snap_t snap_q[$];
   logic  prev_ack = 1'b0;
   pipe_perf_monitor #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .branch_i(branch_i),
      .flush_i(flush_i), .limit_i(limit_i), .snap_req_i(snap_req_i), .snap_ack_o(snap_ack_o),
      .snap_cycle_o(snap_cycle_o), .snap_stall_o(snap_stall_o), .snap_flush_o(snap_flush_o),
      .cycle_o(cycle_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .state_o(state_o), .done_o(done_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic exp_live(input string n, input logic [1:0] st, input logic ack,
                           input int cyc, input int stl, input int fls);
      live_t e;
      e.name = n; e.st = st; e.dn = (st == 2'd2); e.ack = ack;
      e.cyc = W'(cyc); e.stl = W'(stl); e.fls = W'(fls);
      live_q.push_back(e);
   endtask
   task automatic exp_snap(input string n, input int cyc, input int stl, input int fls);
      snap_t e;
      e.name = n; e.cyc = W'(cyc); e.stl = W'(stl); e.fls = W'(fls);
      snap_q.push_back(e);
   endtask
   always @(negedge clk) begin
      while (live_q.size() > 0) begin
         live_t e;
         e = live_q.pop_front();
         chk({e.name, ".state"}, 32'(state_o), 32'(e.st));
         chk({e.name, ".done"}, 32'(done_o), 32'(e.dn));
         chk({e.name, ".ack"}, 32'(snap_ack_o), 32'(e.ack));
         chk({e.name, ".cycle"}, 32'(cycle_o), 32'(e.cyc));
         chk({e.name, ".stall"}, 32'(stall_cnt_o), 32'(e.stl));
         chk({e.name, ".flush"}, 32'(flush_cnt_o), 32'(e.fls));
      end
      if (snap_ack_o && !prev_ack) begin
         if (snap_q.size() == 0) chk("unexpected_snap_ack", 32'(snap_ack_o), 32'd0);
         else begin
            snap_t s;
            s = snap_q.pop_front();
            chk({s.name, ".snap_cycle"}, 32'(snap_cycle_o), 32'(s.cyc));
            chk({s.name, ".snap_stall"}, 32'(snap_stall_o), 32'(s.stl));
            chk({s.name, ".snap_flush"}, 32'(snap_flush_o), 32'(s.fls));
         end
      end
      prev_ack <= snap_ack_o;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_i = 1; start_i = 0; stall_i = 0; branch_i = 0; flush_i = 0; snap_req_i = 0; limit_i = '0;
      tick(); tick();
      exp_live("reset", 0, 0, 0, 0, 0);
      rst_i = 0;
      tick();
      // snapshot in IDLE captures the cleared counters
      snap_req_i = 1; exp_snap("snap_idle", 0, 0, 0);
      tick(); exp_live("snap_idle_ack", 0, 1, 0, 0, 0);
      snap_req_i = 0;
      tick(); exp_live("snap_idle_drop", 0, 0, 0, 0, 0);
      // basic run, limit 10
      start_i = 1; limit_i = 8'd10;
      tick(); exp_live("run10_start", 1, 0, 0, 0, 0);
      start_i = 0; limit_i = 8'd99;
      for (int k = 1; k <= 10; k++) begin
         stall_i = (k == 3 || k == 4); flush_i = (k == 6);
         tick();
         if (k == 5) exp_live("run10_mid", 1, 0, 5, 2, 0);
         if (k == 9) exp_live("run10_c9", 1, 0, 9, 2, 1);
      end
      exp_live("run10_done", 2, 0, 10, 2, 1);
      stall_i = 1; flush_i = 1;
      tick(); tick(); tick();
      exp_live("done_hold", 2, 0, 10, 2, 1);
      stall_i = 0; flush_i = 0;
      snap_req_i = 1; exp_snap("snap_done", 10, 2, 1);
      tick(); snap_req_i = 0;
      tick(); exp_live("snap_done_drop", 2, 0, 10, 2, 1);
      // branch-qualified stalls
      start_i = 1; limit_i = 8'd0;
      tick(); start_i = 0;
      stall_i = 1; branch_i = 1;
      repeat (5) tick();
      exp_live("branch_stall", 1, 0, 5, 0, 0);
      branch_i = 0; flush_i = 1;
      tick(); exp_live("stall_flush_same", 1, 0, 6, 1, 1);
      stall_i = 0; flush_i = 0;
      tick(); exp_live("pre_snap", 1, 0, 7, 1, 1);
      // hold request 4 cycles
      snap_req_i = 1; exp_snap("snap_run", 7, 1, 1);
      for (int k = 0; k < 4; k++) begin
         tick(); exp_live("snap_hold", 1, 1, 8 + k, 1, 1);
      end
      snap_req_i = 0;
      tick(); exp_live("snap_run_drop", 1, 0, 12, 1, 1);
      snap_req_i = 1; exp_snap("snap_again", 12, 1, 1);
      tick(); snap_req_i = 0;
      tick(); exp_live("snap_again_drop", 1, 0, 14, 1, 1);
      // start and capture on the same edge
      start_i = 1; limit_i = 8'd0;
      tick(); start_i = 0;
      repeat (5) tick();
      exp_live("pre_start_snap", 1, 0, 5, 0, 0);
      start_i = 1; snap_req_i = 1; exp_snap("start_snap", 5, 0, 0);
      tick(); exp_live("start_snap_clear", 1, 1, 0, 0, 0);
      start_i = 0; snap_req_i = 0;
      repeat (20) tick();
      exp_live("at20", 1, 0, 20, 0, 0);
      // restart mid-run with limit 3
      start_i = 1; limit_i = 8'd3;
      tick(); exp_live("restart", 1, 0, 0, 0, 0);
      start_i = 0;
      tick(); tick(); exp_live("restart_c2", 1, 0, 2, 0, 0);
      tick(); exp_live("restart_done", 2, 0, 3, 0, 0);
      // limit 1 boundary
      start_i = 1; limit_i = 8'd1;
      tick(); start_i = 0;
      tick(); exp_live("limit1_done", 2, 0, 1, 0, 0);
      // reset mid-run, with start and capture pending
      start_i = 1; limit_i = 8'd0;
      tick(); start_i = 0; stall_i = 1; flush_i = 1;
      repeat (4) tick();
      exp_live("pre_reset", 1, 0, 4, 4, 4);
      rst_i = 1; start_i = 1; snap_req_i = 1;
      tick(); exp_live("reset_prio", 0, 0, 0, 0, 0);
      rst_i = 0; start_i = 0; stall_i = 0; flush_i = 0; exp_snap("snap_after_reset", 0, 0, 0);
      tick(); exp_live("after_reset", 0, 1, 0, 0, 0);
      snap_req_i = 0;
      tick();
      // unlimited run saturates at 2^W-1
      start_i = 1; limit_i = 8'd0;
      tick(); start_i = 0; stall_i = 1; flush_i = 1;
      repeat (300) tick();
      exp_live("saturate", 1, 0, 255, 255, 255);
      stall_i = 0; flush_i = 0;
      tick(); tick();
      checks++;
      if (snap_q.size() != 0) begin
         errors++;
         $display("FAIL snap_queue_drain: got %0d pending expected 0", snap_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
